countdown_display: RTL and testbench

Display-side consumer of the 60 s countdown timer's interface. Takes the timer's 8-bit seconds value `t` and its `done` flag. Converts `t` to three BCD digits with a sequential double-dabble engine, one shift step per clock. Drives three active-low 7-segment digits on the board, with leading-zero blanking and an optional blink when the countdown ends.

---
 rtl/countdown_display.sv | 160 ++++++++++++++++
 tb/tb_countdown_display.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_display.sv
// Seconds-to-7-segment display driver: sequential double-dabble BCD conversion
// with leading-zero blanking. Define COUNTDOWN_BLINK_EN to blink the display while done is high.
module countdown_display #(
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] t,
  input  logic       done,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for a new t value (or the forced post-reset conversion)
  // CONV   | one double-dabble shift step per cycle, 8 steps
  // UPDATE | latch decoded digits into the segment registers
  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  state_t      state, state_nx;
  logic        pending, pending_nx;
  logic [7:0]  t_last, t_last_nx;
  logic [19:0] sr, sr_nx, sr_adj;
  logic [2:0]  step, step_nx;
  logic [6:0]  seg0, seg1, seg2;
  logic [6:0]  seg0_nx, seg1_nx, seg2_nx;
  logic        blank_nx;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  always_comb begin
    sr_adj = sr;
    if (sr[19:16] >= 4'd5) sr_adj[19:16] = sr[19:16] + 4'd3;
    if (sr[15:12] >= 4'd5) sr_adj[15:12] = sr[15:12] + 4'd3;
    if (sr[11:8]  >= 4'd5) sr_adj[11:8]  = sr[11:8]  + 4'd3;
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    t_last_nx  = t_last;
    sr_nx      = sr;
    step_nx    = step;
    seg0_nx    = seg0;
    seg1_nx    = seg1;
    seg2_nx    = seg2;
    case (state)
      IDLE: begin
        if (pending || (t != t_last)) begin
          state_nx   = CONV;
          t_last_nx  = t;
          pending_nx = 1'b0;
          sr_nx      = {12'd0, t};
          step_nx    = 3'd0;
        end
      end
      CONV: begin
        sr_nx   = {sr_adj[18:0], 1'b0};
        step_nx = step + 3'd1;
        if (step == 3'd7) state_nx = UPDATE;
      end
      UPDATE: begin
        seg0_nx  = dec(sr[11:8]);
        seg1_nx  = ((sr[19:16] == 4'd0) && (sr[15:12] == 4'd0)) ? SEG_OFF : dec(sr[15:12]);
        seg2_nx  = (sr[19:16] == 4'd0) ? SEG_OFF : dec(sr[19:16]);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef COUNTDOWN_BLINK_EN
  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic          phase, phase_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_comb begin
    phase_nx = phase;
    cnt_nx   = cnt;
    if (!done) begin
      phase_nx = 1'b0;
      cnt_nx   = '0;
    end else if (cnt == CW'(BLINK_CYCLES - 1)) begin
      phase_nx = ~phase;
      cnt_nx   = '0;
    end else begin
      cnt_nx = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 1'b0;
      cnt   <= '0;
    end else begin
      phase <= phase_nx;
      cnt   <= cnt_nx;
    end
  end

  assign blank_nx = phase_nx;
`else
  logic unused_blink;
  assign unused_blink = done ^ (BLINK_CYCLES == 0);
  assign blank_nx     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pending <= 1'b1;
      t_last  <= 8'd0;
      sr      <= 20'd0;
      step    <= 3'd0;
      seg0    <= SEG_OFF;
      seg1    <= SEG_OFF;
      seg2    <= SEG_OFF;
      hex0    <= SEG_OFF;
      hex1    <= SEG_OFF;
      hex2    <= SEG_OFF;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      t_last  <= t_last_nx;
      sr      <= sr_nx;
      step    <= step_nx;
      seg0    <= seg0_nx;
      seg1    <= seg1_nx;
      seg2    <= seg2_nx;
      // Outputs follow the next-cycle digits so a new conversion and a blink phase flip land on the same edge.
      hex0    <= blank_nx ? SEG_OFF : seg0_nx;
      hex1    <= blank_nx ? SEG_OFF : seg1_nx;
      hex2    <= blank_nx ? SEG_OFF : seg2_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_countdown_display.sv
// Self-checking bench for countdown_display: scoreboard of expected segment
// patterns, exact latency checks, reset abort and (with COUNTDOWN_BLINK_EN) blink.
module tb_countdown_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] t;
  logic       done;
  logic [6:0] hex0, hex1, hex2;
  logic       busy;

  countdown_display #(.BLINK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .t(t), .done(done),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] h0;
    logic [6:0] h1;
    logic [6:0] h2;
  } exp_t;

  exp_t sb[$];
  exp_t shown;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic exp_t model(input int v);
    exp_t e;
    int d0, d1, d2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = v / 100;
    e.h0 = segtab[d0];
    e.h1 = (d2 == 0 && d1 == 0) ? 7'h7F : segtab[d1];
    e.h2 = (d2 == 0) ? 7'h7F : segtab[d2];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 7'(sb.size() != 0), 7'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_hex0"}, hex0, e.h0);
      chk({tag, "_hex1"}, hex1, e.h1);
      chk({tag, "_hex2"}, hex2, e.h2);
      shown = e;
    end
  endtask

  // Exact-latency check: busy high after edges k..k+8 with display unchanged, new digits after k+9.
  task automatic run_check(input string tag);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk({tag, "_busy_hi"}, 7'(busy), 7'd1);
      chk({tag, "_hold"}, hex0, shown.h0);
    end
    @(negedge clk);
    chk({tag, "_busy_lo"}, 7'(busy), 7'd0);
    pop_check(tag);
  endtask

  task automatic conv(input string tag, input logic [7:0] v);
    t = v;
    sb.push_back(model(int'(v)));
    run_check(tag);
  endtask

  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 7'(n < 40), 7'd1);
  endtask

  initial begin
    rst  = 1'b0;
    t    = 8'd60;
    done = 1'b0;
    shown.h0 = 7'h7F; shown.h1 = 7'h7F; shown.h2 = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_hex0", hex0, 7'h7F);
    chk("rst_hex1", hex1, 7'h7F);
    chk("rst_hex2", hex2, 7'h7F);
    chk("rst_busy", 7'(busy), 7'd0);

    rst = 1'b1;
    sb.push_back(model(60));
    @(negedge clk);
    chk("pwrup_busy_rise", 7'(busy), 7'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("pwrup_busy_hi", 7'(busy), 7'd1);
      chk("pwrup_blank", hex0, 7'h7F);
    end
    @(negedge clk);
    chk("pwrup_busy_lo", 7'(busy), 7'd0);
    pop_check("pwrup");

    repeat (2) @(negedge clk);
    conv("t59", 8'd59);
    conv("t255", 8'd255);
    conv("t100", 8'd100);
    conv("t0", 8'd0);
    conv("t5", 8'd5);
    conv("t10", 8'd10);
    conv("t99", 8'd99);

    // Change t three cycles into a conversion: 59 shown first, then 58.
    t = 8'd59;
    sb.push_back(model(59));
    @(negedge clk);
    chk("mid_busy_rise", 7'(busy), 7'd1);
    repeat (3) @(negedge clk);
    t = 8'd58;
    sb.push_back(model(58));
    wait_fall("mid_first");
    pop_check("mid_first");
    @(negedge clk);
    chk("mid_rebusy", 7'(busy), 7'd1);
    wait_fall("mid_second");
    pop_check("mid_second");

    // Reset during CONV step 4 aborts at once; current t reconverted after release.
    @(negedge clk);
    t = 8'd77;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_hex0", hex0, 7'h7F);
    chk("abort_hex1", hex1, 7'h7F);
    chk("abort_hex2", hex2, 7'h7F);
    chk("abort_busy", 7'(busy), 7'd0);
    shown.h0 = 7'h7F; shown.h1 = 7'h7F; shown.h2 = 7'h7F;
    t = 8'd123;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(model(123));
    @(negedge clk);
    chk("rerun_busy_rise", 7'(busy), 7'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rerun_busy_hi", 7'(busy), 7'd1);
      chk("rerun_blank", hex0, 7'h7F);
    end
    @(negedge clk);
    pop_check("rerun");

    conv("blink_t0", 8'd0);
    done = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
`ifdef COUNTDOWN_BLINK_EN
      chk("blink_hex0", hex0, (((n + 1) / 4) % 2 == 1) ? 7'h7F : shown.h0);
      chk("blink_hex1", hex1, 7'h7F);
`else
      chk("noblink_hex0", hex0, shown.h0);
`endif
    end
    done = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("unblink_hex0", hex0, shown.h0);
    end

    chk("sb_drained", 7'(sb.size()), 7'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
